mem_stage: RTL and testbench

//  MIPS memory stage plus MEM/WB pipeline register; sits between EX/MEM and writeback.
//  - Performs data-memory load/store and resolves branch PCSrc.
//  - Registers {MemToReg,RegWrite}, load data, ALU result and destination register.
//  - These registers feed the writeback mux.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mem_stage_dmem.sv | 23 ++
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, control-bit positions and the MEM/WB payload for the MIPS memory stage.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned M_W    = 3;

  localparam int unsigned WB_MEMTOREG = 1;
  localparam int unsigned WB_REGWRITE = 0;
  localparam int unsigned M_BRANCH    = 2;
  localparam int unsigned M_MEMREAD   = 1;
  localparam int unsigned M_MEMWRITE  = 0;

  typedef struct packed {
    logic              valid;
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  write_reg;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_dmem.sv
// Data memory: DEPTH x 32 words, synchronous write, asynchronous read, no reset.
module dmem
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-memory access, branch PCSrc and the MEM/WB pipeline register.
// Optional MEM_STAGE_ALIGN_CHECK_EN adds align_err and blocks misaligned accesses.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [WB_W-1:0]   ex_wb,
  input  logic [M_W-1:0]    ex_m,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  output logic              pcsrc,
  output logic [WB_W-1:0]   mem_wb,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [REG_W-1:0]  write_reg,
  output logic              wb_valid
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

  logic              w_branch;
  logic              w_memread;
  logic              w_memwrite;
  logic              w_misalign;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rdata;
  mem_wb_t           w_mwb_d;
  mem_wb_t           r_mwb;

  assign w_branch   = ex_m[M_BRANCH];
  assign w_memread  = ex_m[M_MEMREAD];
  assign w_memwrite = ex_m[M_MEMWRITE];
  assign w_addr     = ex_alu_result[ADDR_W+1:2];

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign w_misalign = (w_memread | w_memwrite) & ex_valid & (ex_alu_result[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // rst_n in the enable drops a store whose edge lands inside reset.
  assign w_we  = w_memwrite & ex_valid & ~stall & ~flush & rst_n & ~w_misalign;
  assign pcsrc = w_branch & ex_zero & ex_valid & ~flush;

  dmem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_addr),
    .wdata (ex_write_data),
    .rdata (w_rdata)
  );

  // Next MEM/WB payload when the stage advances.
  always_comb begin
    w_mwb_d            = '0;
    w_mwb_d.valid      = ex_valid;
    w_mwb_d.read_data  = w_memread ? w_rdata : '0;
    w_mwb_d.alu_result = ex_alu_result;
    w_mwb_d.write_reg  = ex_write_reg;
    if (ex_valid) begin
      w_mwb_d.wb = ex_wb;
      if (w_misalign & w_memread) w_mwb_d.wb[WB_REGWRITE] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mwb <= '0;
    end else if (flush) begin
      r_mwb <= '0;
    end else if (!stall) begin
      r_mwb <= w_mwb_d;
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic r_align_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align_err <= 1'b0;
    end else if (flush) begin
      r_align_err <= 1'b0;
    end else if (!stall) begin
      r_align_err <= w_misalign;
    end
  end

  assign align_err = r_align_err;
`endif

  assign wb_valid   = r_mwb.valid;
  assign mem_wb     = r_mwb.wb;
  assign read_data  = r_mwb.read_data;
  assign alu_result = r_mwb.alu_result;
  assign write_reg  = r_mwb.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: reference model pushes expected MEM/WB contents, monitor pops.
module tb_mem_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        aerr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;
  logic [31:0] ex_alu_result;
  logic        ex_zero;
  logic [31:0] ex_write_data;
  logic [4:0]  ex_write_reg;
  logic        pcsrc;
  logic [1:0]  mem_wb;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic        wb_valid;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  exp_t        m_reg = '0;
  logic [31:0] m_mem [int];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_wb         (ex_wb),
    .ex_m          (ex_m),
    .ex_alu_result (ex_alu_result),
    .ex_zero       (ex_zero),
    .ex_write_data (ex_write_data),
    .ex_write_reg  (ex_write_reg),
    .pcsrc         (pcsrc),
    .mem_wb        (mem_wb),
    .read_data     (read_data),
    .alu_result    (alu_result),
    .write_reg     (write_reg),
    .wb_valid      (wb_valid)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    .align_err     (align_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one EX/MEM slot at negedge, check pcsrc, and push the expected MEM/WB contents.
  task automatic apply(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] addr, input logic z, input logic [31:0] wd,
                       input logic [4:0] wr, input logic st, input logic fl);
    exp_t        nxt;
    logic        mis;
    int          idx;
    logic [31:0] rd;
    @(negedge clk);
    ex_valid = v; ex_wb = wb; ex_m = m; ex_alu_result = addr; ex_zero = z;
    ex_write_data = wd; ex_write_reg = wr; stall = st; flush = fl;
    mis = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    mis = (m[1] | m[0]) & v & (addr[1:0] != 2'b00);
`endif
    idx = int'(addr[9:2]);
    rd  = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
    #1;
    check("pcsrc", 32'(pcsrc), 32'(m[2] & z & v & ~fl));
    nxt = '0;
    if (fl) begin
      nxt = '0;
    end else if (st) begin
      nxt = m_reg;
    end else begin
      nxt.valid = v;
      nxt.wb    = v ? wb : 2'b00;
      if (mis & m[1]) nxt.wb[0] = 1'b0;
      nxt.rd    = m[1] ? rd : 32'h0;
      nxt.alu   = addr;
      nxt.wr    = wr;
      nxt.aerr  = mis;
    end
    if (m[0] & v & ~st & ~fl & ~mis) m_mem[idx] = wd;
    m_reg = nxt;
    sb.push_back(nxt);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(wb_valid), 32'h0);
    check({tag, "_mem_wb"}, 32'(mem_wb), 32'h0);
    check({tag, "_read_data"}, read_data, 32'h0);
    check({tag, "_alu_result"}, alu_result, 32'h0);
    check({tag, "_write_reg"}, 32'(write_reg), 32'h0);
  endtask

  // Monitor: compare MEM/WB outputs just after each capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_valid", 32'(wb_valid), 32'(e.valid));
        check("sb_mem_wb", 32'(mem_wb), 32'(e.wb));
        check("sb_read_data", read_data, e.rd);
        check("sb_alu_result", alu_result, e.alu);
        check("sb_write_reg", 32'(write_reg), 32'(e.wr));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        check("sb_align_err", 32'(align_err), 32'(e.aerr));
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_wb = '0; ex_m = '0;
    ex_alu_result = '0; ex_zero = 1'b0; ex_write_data = '0; ex_write_reg = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Store then load.
    apply(1'b1, 2'b00, 3'b001, 32'h10, 1'b0, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd9, 1'b0, 1'b0);
    settle();
    check("lw_data", read_data, 32'hDEADBEEF);
    check("lw_mem_wb", 32'(mem_wb), 32'h3);
    check("lw_write_reg", 32'(write_reg), 32'd9);

    // Branch resolution.
    apply(1'b1, 2'b00, 3'b100, 32'h0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 2'b00, 3'b100, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 2'b00, 3'b100, 32'h0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b1);
    apply(1'b0, 2'b00, 3'b100, 32'h0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);

    // Stall holds MEM/WB and suppresses the store.
    apply(1'b1, 2'b00, 3'b001, 32'h20, 1'b0, 32'h12345678, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd3, 1'b0, 1'b0);
    apply(1'b1, 2'b00, 3'b001, 32'h20, 1'b0, 32'h00000BAD, 5'd0, 1'b1, 1'b0);
    apply(1'b1, 2'b00, 3'b001, 32'h20, 1'b0, 32'h00000BAD, 5'd0, 1'b1, 1'b0);
    settle();
    check("stall_hold_data", read_data, 32'hDEADBEEF);
    check("stall_hold_reg", 32'(write_reg), 32'd3);
    apply(1'b1, 2'b11, 3'b010, 32'h20, 1'b0, 32'h0, 5'd4, 1'b0, 1'b0);
    settle();
    check("stall_no_store", read_data, 32'h12345678);

    // Flush and stall together: bubble, no store.
    apply(1'b1, 2'b11, 3'b001, 32'h20, 1'b0, 32'h0000BAD2, 5'd7, 1'b1, 1'b1);
    settle();
    check("flush_valid", 32'(wb_valid), 32'h0);
    check("flush_mem_wb", 32'(mem_wb), 32'h0);
    apply(1'b0, 2'b11, 3'b001, 32'h20, 1'b0, 32'h0000BAD3, 5'd7, 1'b0, 1'b0);
    apply(1'b1, 2'b11, 3'b010, 32'h20, 1'b0, 32'h0, 5'd4, 1'b0, 1'b0);
    settle();
    check("flush_no_store", read_data, 32'h12345678);

    // Address wrap modulo DEPTH.
    apply(1'b1, 2'b00, 3'b001, 32'h408, 1'b0, 32'hA5A50001, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 2'b11, 3'b010, 32'h8, 1'b0, 32'h0, 5'd8, 1'b0, 1'b0);
    settle();
    check("wrap_data", read_data, 32'hA5A50001);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    apply(1'b1, 2'b00, 3'b001, 32'h9, 1'b0, 32'h0000BAD4, 5'd0, 1'b0, 1'b0);
    settle();
    check("align_err_set", 32'(align_err), 32'h1);
    apply(1'b1, 2'b11, 3'b010, 32'h8, 1'b0, 32'h0, 5'd8, 1'b0, 1'b0);
    settle();
    check("align_no_store", read_data, 32'hA5A50001);
`endif

    // Reset mid-run: outputs clear immediately, pending store dropped.
    apply(1'b1, 2'b00, 3'b001, 32'h40, 1'b0, 32'h11111111, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 2'b11, 3'b010, 32'h40, 1'b0, 32'h0, 5'd12, 1'b0, 1'b0);
    settle();
    check("pre_reset_data", read_data, 32'h11111111);
    @(negedge clk);
    ex_valid = 1'b1; ex_wb = 2'b00; ex_m = 3'b001; ex_alu_result = 32'h40;
    ex_write_data = 32'h22222222; ex_write_reg = 5'd0; stall = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    m_reg = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b0;
    apply(1'b1, 2'b11, 3'b010, 32'h40, 1'b0, 32'h0, 5'd10, 1'b0, 1'b0);
    settle();
    check("reset_drop_store", read_data, 32'h11111111);

    apply(1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
